// File: rtl/sram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module : sram_arb_pkg
// Brief  : Shared types, constants and the round-robin search helper used by
//          the SRAM port arbiter and its priority picker.
// Rev    : 1.0  initial release
// ============================================================================
package sram_arb_pkg;

  // Arbiter FSM: free round-robin, or a requester holds a locked burst
  typedef enum logic [0:0] {
    IDLE_RR = 1'b0,
    LOCKED  = 1'b1
  } arb_state_t;

  localparam int DEFAULT_ADDR_W = 10;
  localparam int DEFAULT_DATA_W = 16;

  // Widest requester vector the helper handles; callers zero-pad down to it
  localparam int MAX_REQ  = 8;
  localparam int RR_IDX_W = 3;

  // First set bit of req at or after start, wrapping modulo n.
  // Returns start when nothing is set; callers qualify with |req.
  function automatic logic [RR_IDX_W-1:0] rr_first_index(
    input logic [MAX_REQ-1:0]  req,
    input logic [RR_IDX_W-1:0] start,
    input logic [RR_IDX_W:0]   n
  );
    logic              found;
    logic [RR_IDX_W:0] pos;
    rr_first_index = start;
    found          = 1'b0;
    for (int k = 0; k < MAX_REQ; k++) begin
      // start < n and k < n, so at most one wrap correction is needed
      pos = {1'b0, start} + (RR_IDX_W + 1)'(k);
      if (pos >= n) pos = pos - n;
      if (!found && ((RR_IDX_W + 1)'(k) < n) && req[pos[RR_IDX_W-1:0]]) begin
        rr_first_index = pos[RR_IDX_W-1:0];
        found          = 1'b1;
      end
    end
  endfunction

endpackage : sram_arb_pkg
`default_nettype wire

// File: rtl/sram_port_arbiter_rr_priority_pick.sv
`default_nettype none
// ============================================================================
// Module : rr_priority_pick
// Brief  : Combinational round-robin picker. Returns the first requesting
//          index at or after start_ptr (wrapping) as one-hot and as an index.
// Rev    : 1.0  initial release
// ============================================================================
module rr_priority_pick
  import sram_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_vec,
  input  logic [IDX_W-1:0]   start_ptr,
  output logic [NUM_REQ-1:0] pick_onehot,
  output logic [IDX_W-1:0]   pick_idx,
  output logic               pick_valid
);

  logic [MAX_REQ-1:0]  req_pad;
  logic [RR_IDX_W-1:0] first_idx;

  // Pad the request vector to the helper width and search from start_ptr
  always_comb begin
    req_pad                = '0;
    req_pad[NUM_REQ-1:0]   = req_vec;
    first_idx              = rr_first_index(req_pad, RR_IDX_W'(start_ptr),
                                            (RR_IDX_W + 1)'(NUM_REQ));
    pick_valid             = |req_vec;
    pick_idx               = IDX_W'(first_idx);
    pick_onehot            = pick_valid ? (NUM_REQ'(1) << pick_idx) : '0;
  end

endmodule : rr_priority_pick
`default_nettype wire

// File: rtl/sram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module : sram_port_arbiter
// Brief  : Shares one SRAM port between NUM_REQ requesters. Same-cycle
//          round-robin grants, optional locked bursts capped at MAX_BURST
//          beats while others wait, and a per-requester read-valid strobe
//          aligned to the SRAM's one-cycle read latency.
// Rev    : 1.0  initial release
// ============================================================================
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int ADDR_W    = DEFAULT_ADDR_W,
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter int MAX_BURST = 8
) (
  input  logic                        clock,
  input  logic                        nReset,
  input  logic [NUM_REQ-1:0]          reqVector,
  input  logic [NUM_REQ-1:0]          lockVector,
  input  logic [NUM_REQ-1:0]          reqWriteEnable,
  input  logic [NUM_REQ*ADDR_W-1:0]   reqAddress,
  input  logic [NUM_REQ*DATA_W-1:0]   reqDataIn,
  output logic [NUM_REQ-1:0]          grantVector,
  output logic [NUM_REQ-1:0]          readValidVector,
  output logic [DATA_W-1:0]           readData,
  output logic                        sramWriteEnable,
  output logic [ADDR_W-1:0]           sramAddress,
  output logic [DATA_W-1:0]           sramDataIn,
  input  logic [DATA_W-1:0]           sramDataOut
);

  localparam int                IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int                CNT_W     = 8;
  localparam logic [CNT_W-1:0]  BURST_CAP = CNT_W'(MAX_BURST);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_REQ - 1);

  arb_state_t         state_q,    state_d;
  logic [IDX_W-1:0]   owner_q,    owner_d;
  logic [CNT_W-1:0]   burst_q,    burst_d;
  logic [IDX_W-1:0]   rr_ptr_q,   rr_ptr_d;
  logic [NUM_REQ-1:0] rd_valid_q, rd_valid_d;

  logic [NUM_REQ-1:0] owner_onehot;
  logic               owner_holds;
  logic               others_waiting;
  logic               cap_reached;
  logic               stay_locked;
  logic               cap_exit;
  logic [NUM_REQ-1:0] rr_req;

  logic [NUM_REQ-1:0] pick_onehot;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_valid;

  logic [NUM_REQ-1:0] grant_onehot;
  logic [ADDR_W-1:0]  mux_addr;
  logic [DATA_W-1:0]  mux_data;

  // Decide whether the current owner keeps the port or the burst ends
  always_comb begin
    owner_onehot   = NUM_REQ'(1) << owner_q;
    owner_holds    = reqVector[owner_q] & lockVector[owner_q];
    others_waiting = |(reqVector & ~owner_onehot);
    cap_reached    = (burst_q >= BURST_CAP);
    stay_locked    = (state_q == LOCKED) && owner_holds &&
                     !(cap_reached && others_waiting);
    // A cap-triggered exit must hand the port to someone else this cycle
    cap_exit       = (state_q == LOCKED) && owner_holds &&
                     cap_reached && others_waiting;
    rr_req         = cap_exit ? (reqVector & ~owner_onehot) : reqVector;
  end

  rr_priority_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req_vec     (rr_req),
    .start_ptr   (rr_ptr_q),
    .pick_onehot (pick_onehot),
    .pick_idx    (pick_idx),
    .pick_valid  (pick_valid)
  );

  // Same-cycle grant; forced off while reset is held
  always_comb begin
    grant_onehot = '0;
    if (nReset) begin
      grant_onehot = stay_locked ? owner_onehot : pick_onehot;
    end
  end

  // Steer the granted requester onto the SRAM port, zero when idle
  always_comb begin
    mux_addr = '0;
    mux_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_onehot[i]) begin
        mux_addr = reqAddress[i*ADDR_W +: ADDR_W];
        mux_data = reqDataIn[i*DATA_W +: DATA_W];
      end
    end
  end

  // Next-state for the FSM, burst counter, pointer and read-valid pipe
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    burst_d    = burst_q;
    rr_ptr_d   = rr_ptr_q;
    rd_valid_d = grant_onehot & ~reqWriteEnable;
    if (stay_locked) begin
      if (burst_q < BURST_CAP) burst_d = burst_q + CNT_W'(1);
    end else begin
      // Leaving LOCKED or already idle: round-robin runs without a bubble
      state_d = IDLE_RR;
      burst_d = '0;
      if (pick_valid) begin
        rr_ptr_d = (pick_idx == LAST_IDX) ? '0 : pick_idx + IDX_W'(1);
        if (lockVector[pick_idx]) begin
          state_d = LOCKED;
          owner_d = pick_idx;
          burst_d = CNT_W'(1);
        end
      end
    end
  end

  // State registers with asynchronous clear
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      state_q    <= IDLE_RR;
      owner_q    <= '0;
      burst_q    <= '0;
      rr_ptr_q   <= '0;
      rd_valid_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      burst_q    <= burst_d;
      rr_ptr_q   <= rr_ptr_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign grantVector     = grant_onehot;
  assign sramWriteEnable = |(grant_onehot & reqWriteEnable);
  assign sramAddress     = mux_addr;
  assign sramDataIn      = mux_data;
  assign readValidVector = rd_valid_q;
  assign readData        = sramDataOut;

endmodule : sram_port_arbiter
`default_nettype wire
